// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART receive path: receiver FSM state encoding,
// oversampling constants and the debug view of the receiver's internal state.
// Imported by uart_rx and any block that wants to observe its debug port.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Oversampling ratio of the baud tick relative to the bit rate.
    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

    // Tick count at which the start bit is re-checked (middle of start bit)
    // and at which data/stop bits are sampled (one full bit later each).
    localparam logic [TICK_W-1:0] MID_SAMPLE  = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_SAMPLE = TICK_W'(OVERSAMPLE - 1);

    // Wide enough to count up to 9 data bits.
    localparam int BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_rx_state_t;

    // Observation bundle exported by uart_rx so checkers can follow the FSM.
    typedef struct packed {
        uart_rx_state_t         state;
        logic [TICK_W-1:0]      tick_cnt;
        logic [BIT_CNT_W-1:0]   bit_cnt;
    } uart_rx_dbg_t;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//
// Multi-stage flip-flop synchronizer for a single asynchronous input.
// The reset level is a parameter so the same block can guard lines that idle
// high (UART rx) or low.
//
// Ports:
//   clk      in   destination clock
//   rst      in   asynchronous, active-high reset
//   async_i  in   asynchronous input
//   sync_o   out  input resampled into the clk domain (STAGES clks of delay)
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule : uart_sync

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receiver (8N1 by default). The rx line is synchronized, then sampled
// with a 16x baud tick: a falling edge is confirmed at the middle of the start
// bit, each data bit is sampled one bit-time later (LSB first), and the stop
// bit is checked at its middle. Completed bytes go to a one-entry output
// register; framing and overrun errors are single-cycle pulses.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   en             in   receiver enable (same enable as the baud generator)
//   baud_x16_tick  in   one-cycle pulse at 16x the bit rate
//   rx             in   asynchronous serial input, idles high
//   rx_data        out  received byte, LSB = first data bit
//   rx_valid       out  rx_data holds an unconsumed byte
//   rx_ready       in   consumer accepts rx_data
//   frame_err      out  one-cycle pulse: stop bit sampled low
//   overrun_err    out  one-cycle pulse: completed byte dropped, buffer full
//   dbg            out  FSM state and counters for observation
//
// Output handshake: a byte transfers on every clock edge where
// rx_valid && rx_ready. While rx_valid=1 and rx_ready=0, rx_data is held
// unchanged. A new byte may be loaded on the same edge a held byte is
// accepted; in that case rx_valid simply stays high.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 baud_x16_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output uart_rx_dbg_t         dbg
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (rx),
        .sync_o  (rx_s)
    );

    uart_rx_state_t         state_q;
    logic [TICK_W-1:0]      tick_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
    logic                   overrun_err_q;

    // Bits arrive LSB first: each new sample enters at the MSB and the word
    // moves right, so after DATA_BITS samples the first bit sits at bit 0.
    always_comb begin
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;

            // Consumer side works regardless of en; a delivery below on the
            // same edge overrides this clear.
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (!en) begin
                state_q    <= IDLE;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else if (baud_x16_tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                        end
                    end

                    START: begin
                        if (tick_cnt_q == MID_SAMPLE) begin
                            // Line must still be low at mid start bit,
                            // otherwise it was a glitch: silently drop it.
                            if (!rx_s) begin
                                state_q    <= DATA;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end

                    DATA: begin
                        // tick_cnt wraps 15->0 here, which also restarts the
                        // count for the next bit (or for the stop bit).
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                        if (tick_cnt_q == LAST_SAMPLE) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q    <= STOP;
                                tick_cnt_q <= '0;
                            end
                        end
                    end

                    STOP: begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                        if (tick_cnt_q == LAST_SAMPLE) begin
                            tick_cnt_q <= '0;
                            if (rx_s) begin
                                // Return to IDLE at mid stop bit so a start
                                // edge right after the stop bit is caught.
                                state_q <= IDLE;
                                if (!rx_valid_q || rx_ready) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_err_q <= 1'b1;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_IDLE;
                            end
                        end
                    end

                    WAIT_IDLE: begin
                        // Hold off until the line returns high so a break
                        // does not look like an endless stream of frames.
                        tick_cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        state_q    <= IDLE;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign frame_err    = frame_err_q;
    assign overrun_err  = overrun_err_q;

    assign dbg.state    = state_q;
    assign dbg.tick_cnt = tick_cnt_q;
    assign dbg.bit_cnt  = bit_cnt_q;

endmodule : uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 by default; the consumer end of the baud tick interface.
- Oversamples the asynchronous rx line using the 16x baud tick from the baud generator. Samples mid-bit and frames bits LSB first.
- Delivers each byte through a one-entry valid/ready output register. Reports framing and overrun errors as single-cycle pulses.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- SYNC_STAGES, 2, flip-flop stages synchronizing rx into the clk domain (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  receiver enable; tie to the same enable as the baud generator
- baud_x16_tick  in  1  one-cycle pulse at baud*16
- rx  in  1  serial input, asynchronous, idles high
- rx_data  out  DATA_BITS  received byte, LSB = first data bit
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun_err  out  1  one-cycle pulse: a completed byte was dropped because the buffer was full

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun_err=0.
  - Synchronizer flops = 1 (idle).
  - FSM = IDLE; tick_cnt=0, bit_cnt=0, shift register=0.
- The FSM and counters advance only in cycles where baud_x16_tick=1. All sampling uses the synchronized rx_s.
- tick_cnt is 4 bits and wraps 15->0.
- IDLE:
  - On a tick with rx_s=0: go to START, tick_cnt=0.
- START:
  - On each tick, tick_cnt++.
  - On the tick where tick_cnt==7 (8th low tick, mid start bit):
    - rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
    - rx_s=1 -> IDLE. Glitch rejected, no error reported.
- DATA:
  - On the tick where tick_cnt==15 (mid-bit): shift rx_s into the MSB of the shift register (right shift, LSB first), bit_cnt++.
  - After DATA_BITS samples -> STOP, tick_cnt=0.
- STOP:
  - On the tick where tick_cnt==15 (mid stop bit):
    - rx_s=1 -> deliver the byte, go to IDLE. Early return allows back-to-back frames.
    - rx_s=0 -> pulse frame_err in the next cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until a tick with rx_s=1, then go to IDLE. This prevents a break condition from re-triggering frames.
- Delivery, registered in the cycle after the stop-sampling tick:
  - Buffer empty, or rx_ready=1 in the delivery cycle: rx_data<=byte, rx_valid<=1. A simultaneous accept plus load keeps rx_valid=1 and raises no overrun.
  - Buffer full and rx_ready=0: keep the old rx_data, pulse overrun_err, drop the new byte.
- Consumption without a new byte: rx_valid && rx_ready -> rx_valid<=0 next cycle.
- rx_data is stable while rx_valid=1 and not accepted.
- en=0:
  - FSM forced to IDLE; tick_cnt and bit_cnt cleared; no error pulses.
  - rx_data, rx_valid and the handshake are retained and still consumable.
- Reset mid-frame: everything returns to reset values immediately (async). A partial frame is lost with no error.
- Latency: rx_valid rises 1 clk after the tick that samples the stop bit, i.e. about 9.5 bit times after the start edge (8N1), plus the synchronizer delay of SYNC_STAGES clks.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - localparams OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15.
- Sub-module uart_sync: a SYNC_STAGES-deep synchronizer with reset value 1 and a parameterized reset level. It is reusable for other asynchronous inputs.

Test Plan:
- Bench setup: baud generator at div_x16=4, rx_ready=1 unless stated.
- Frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 cycle, starting 1 clk after the stop-mid tick. No errors.
- rx low for 5 ticks, then high -> no rx_valid, no frame_err; FSM back in IDLE. A following 0x3C frame is received correctly.
- Frame 0x3C with stop bit low, then rx held low 20 bit times, then frame 0x55 -> one frame_err pulse, no rx_valid for 0x3C, no spurious frames during the break, then rx_data=0x55.
- rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_valid=1, rx_data stays 0x11, one overrun_err pulse at the 0x22 delivery. Raising rx_ready then clears rx_valid.
- rx_ready=1 asserted in the same cycle the second byte 0x22 completes over a held 0x11 -> rx_data=0x22, rx_valid stays 1, no overrun_err.
- Mid-frame interruption:
  - Assert rst mid-DATA of 0xF0 -> outputs are 0 immediately.
  - Separately, deassert en mid-DATA -> FSM to IDLE, no valid or error; the next full frame 0x0F is received correctly after en=1.
